// File: rtl/display_layer_scheduler.sv
// display_layer_scheduler
//   Page sequencer and per-pixel layer compositor for the RGB LCD path.
//   Picks the active page (CLOCK / BANNER / ALARM) on frame boundaries only,
//   so a page never tears mid-frame, and muxes the renderer layers into
//   LCD_R/G/B with one PixelClk of latency.
//
//   Optional build macro: LAYER_SCHED_DIM_EN
//     When defined, clock-layer pixels shown on the BANNER page (where the
//     banner itself does not cover the pixel) are halved per channel.
//
//   Ports
//     PixelClk, nRST            pixel clock, async active-low reset
//     PixelCount, LineCount     raster position from the LCD timing block
//     display_mode              mode select; any change raises a banner
//     set_active                time edit in progress; drives blink
//     alarm_req, alarm_ack      single-cycle alarm fire / dismiss pulses
//     clk_*, mode_*, alarm_*    layer colour {R5,G6,B5} and hit flag
//     LCD_R, LCD_G, LCD_B       composited colour (registered)
//     page                      active page: 0 CLOCK, 1 BANNER, 2 ALARM
//     blink                     edit-field flash phase
//     frame_start               one-cycle pulse at the start of each frame
//
//   state  | meaning
//   CLOCK  | normal time display
//   BANNER | mode banner over (optionally dimmed) clock, timed in frames
//   ALARM  | alarm banner until dismissed
module display_layer_scheduler #(
  parameter int          H_ACTIVE      = 800,
  parameter int          V_ACTIVE      = 480,
  parameter int          BANNER_FRAMES = 120,
  parameter int          BLINK_FRAMES  = 30,
  parameter logic [15:0] BG_RGB        = 16'h0000
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic [15:0] PixelCount,
  input  logic [15:0] LineCount,
  input  logic [2:0]  display_mode,
  input  logic        set_active,
  input  logic        alarm_req,
  input  logic        alarm_ack,
  input  logic [15:0] clk_rgb,
  input  logic        clk_hit,
  input  logic [15:0] mode_rgb,
  input  logic        mode_hit,
  input  logic [15:0] alarm_rgb,
  input  logic        alarm_hit,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic [1:0]  page,
  output logic        blink,
  output logic        frame_start
);

  localparam logic [1:0]  PG_CLOCK    = 2'd0;
  localparam logic [1:0]  PG_BANNER   = 2'd1;
  localparam logic [1:0]  PG_ALARM    = 2'd2;
  localparam logic [15:0] H_LIM       = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM       = 16'(V_ACTIVE);
  localparam logic [15:0] BANNER_LOAD = 16'(BANNER_FRAMES - 1);
  localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_FRAMES - 1);

  logic        origin;
  logic        origin_q;
  logic [2:0]  mode_q;
  logic        mode_valid;
  logic        mode_pend;
  logic        alarm_pend;
  logic        ack_pend;
  logic [15:0] frame_cnt;
  logic [7:0]  blink_cnt;
  logic        blank;
  logic [15:0] clk_px;
  logic [15:0] pix;

  assign origin = (PixelCount == 16'd0) && (LineCount == 16'd0);

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      origin_q    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      origin_q    <= origin;
      frame_start <= origin & ~origin_q;
    end
  end

  // Page FSM and event latching share the pend flags. Consumption is written
  // first so that an event arriving on the consuming frame_start survives.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      page       <= PG_CLOCK;
      frame_cnt  <= 16'd0;
      mode_q     <= 3'd0;
      mode_valid <= 1'b0;
      mode_pend  <= 1'b0;
      alarm_pend <= 1'b0;
      ack_pend   <= 1'b0;
    end else begin
      if (frame_start) begin
        if (alarm_pend) begin
          page       <= PG_ALARM;
          alarm_pend <= 1'b0;
          ack_pend   <= 1'b0;
        end else begin
          case (page)
            PG_ALARM: begin
              if (ack_pend) begin
                ack_pend <= 1'b0;
                if (mode_pend) begin
                  page      <= PG_BANNER;
                  frame_cnt <= BANNER_LOAD;
                  mode_pend <= 1'b0;
                end else begin
                  page <= PG_CLOCK;
                end
              end
            end
            PG_BANNER: begin
              if (mode_pend) begin
                frame_cnt <= BANNER_LOAD;
                mode_pend <= 1'b0;
              end else if (frame_cnt == 16'd0) begin
                page <= PG_CLOCK;
              end else begin
                frame_cnt <= frame_cnt - 16'd1;
              end
            end
            default: begin
              if (mode_pend) begin
                page      <= PG_BANNER;
                frame_cnt <= BANNER_LOAD;
                mode_pend <= 1'b0;
              end
            end
          endcase
        end
      end

      // The first clock after reset only captures the mode, without an event.
      mode_valid <= 1'b1;
      if (!mode_valid) begin
        mode_q <= display_mode;
      end else if (display_mode != mode_q) begin
        mode_q    <= display_mode;
        mode_pend <= 1'b1;
      end

      if (alarm_req) begin
        alarm_pend <= 1'b1;
      end else if (alarm_ack && ((page == PG_ALARM) || alarm_pend)) begin
        ack_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      blink     <= 1'b0;
      blink_cnt <= 8'd0;
    end else if (!set_active) begin
      blink     <= 1'b0;
      blink_cnt <= 8'd0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= 8'd0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    clk_px = clk_rgb;
`ifdef LAYER_SCHED_DIM_EN
    if (page == PG_BANNER) begin
      clk_px = {1'b0, clk_rgb[15:12], 1'b0, clk_rgb[10:6], 1'b0, clk_rgb[4:1]};
    end
`endif
    blank = (PixelCount >= H_LIM) || (LineCount >= V_LIM);
    pix   = BG_RGB;
    case (page)
      PG_ALARM:  if (alarm_hit) pix = alarm_rgb;
      PG_BANNER: begin
        if (mode_hit)     pix = mode_rgb;
        else if (clk_hit) pix = clk_px;
      end
      default:   if (clk_hit) pix = clk_px;
    endcase
    if (blank) pix = 16'h0000;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_R <= 5'd0;
      LCD_G <= 6'd0;
      LCD_B <= 5'd0;
    end else begin
      LCD_R <= pix[15:11];
      LCD_G <= pix[10:5];
      LCD_B <= pix[4:0];
    end
  end

endmodule

// File: tb/tb_display_layer_scheduler.sv
// Bench for display_layer_scheduler on a reduced 10x5 raster (8x4 active).
// Expected pixels go into a queue when driven and are compared one cycle
// later; page/blink/frame_start are compared against per-frame constants.
module tb_display_layer_scheduler;
  localparam int H_TOT = 10;
  localparam int V_TOT = 5;
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;

  logic        PixelClk = 1'b0;
  logic        nRST;
  logic [15:0] PixelCount, LineCount;
  logic [2:0]  display_mode;
  logic        set_active, alarm_req, alarm_ack;
  logic [15:0] clk_rgb, mode_rgb, alarm_rgb;
  logic        clk_hit, mode_hit, alarm_hit;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [1:0]  page;
  logic        blink, frame_start;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] sb[$];
  logic [1:0]  prev_pg = 2'd0;

  display_layer_scheduler #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BANNER_FRAMES(3),
    .BLINK_FRAMES(2), .BG_RGB(16'h0000)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .PixelCount(PixelCount), .LineCount(LineCount),
    .display_mode(display_mode), .set_active(set_active),
    .alarm_req(alarm_req), .alarm_ack(alarm_ack),
    .clk_rgb(clk_rgb), .clk_hit(clk_hit), .mode_rgb(mode_rgb), .mode_hit(mode_hit),
    .alarm_rgb(alarm_rgb), .alarm_hit(alarm_hit),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .page(page), .blink(blink), .frame_start(frame_start)
  );

  always #5 PixelClk = ~PixelClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] dim(input logic [15:0] c);
`ifdef LAYER_SCHED_DIM_EN
    return {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]};
`else
    return c;
`endif
  endfunction

  function automatic logic [15:0] model_pix(input int px, input int ln, input logic [1:0] pg);
    if (px >= H_ACT || ln >= V_ACT) return 16'h0000;
    case (pg)
      2'd2:    return alarm_hit ? alarm_rgb : 16'h0000;
      2'd1:    return mode_hit ? mode_rgb : (clk_hit ? dim(clk_rgb) : 16'h0000);
      default: return clk_hit ? clk_rgb : 16'h0000;
    endcase
  endfunction

  // One pixel: compare the previous pixel's output, then drive the next one.
  task automatic step(input int px, input int ln, input logic [1:0] pg);
    @(negedge PixelClk);
    if (sb.size() > 0) chk("lcd", {16'h0, LCD_R, LCD_G, LCD_B}, {16'h0, sb.pop_front()});
    PixelCount = 16'(px);
    LineCount  = 16'(ln);
    clk_rgb    = 16'($urandom);
    mode_rgb   = 16'($urandom);
    alarm_rgb  = 16'($urandom);
    clk_hit    = 1'($urandom);
    mode_hit   = 1'($urandom);
    alarm_hit  = 1'($urandom);
    sb.push_back(model_pix(px, ln, pg));
  endtask

  // The page registered on frame_start is first used by the compositor for
  // the third pixel of the frame; the first two still show the old page.
  task automatic run_frame(input logic [1:0] pg, input logic [2:0] mode, input logic req,
                           input logic ack, input logic sa, input logic bl, input logic early);
    for (int c = 0; c < H_TOT * V_TOT; c++) begin
      step(c % H_TOT, c / H_TOT, (c < 2) ? prev_pg : pg);
      case (c)
        0:  set_active = sa;
        1: begin
          chk("frame_start_hi", {31'h0, frame_start}, 32'd1);
          if (early) chk("blink_clear", {31'h0, blink}, {31'h0, bl});
        end
        2:  chk("frame_start_lo", {31'h0, frame_start}, 32'd0);
        20: begin
          display_mode = mode;
          alarm_req    = req;
          alarm_ack    = ack;
        end
        21: begin
          alarm_req = 1'b0;
          alarm_ack = 1'b0;
        end
        30: begin
          chk("page", {30'h0, page}, {30'h0, pg});
          chk("blink", {31'h0, blink}, {31'h0, bl});
        end
        default: ;
      endcase
    end
    prev_pg = pg;
  endtask

  initial begin
    nRST = 1'b0;
    PixelCount = 16'd9; LineCount = 16'd4;
    display_mode = 3'd1; set_active = 1'b0; alarm_req = 1'b0; alarm_ack = 1'b0;
    clk_rgb = 16'hFFFF; mode_rgb = 16'hFFFF; alarm_rgb = 16'hFFFF;
    clk_hit = 1'b1; mode_hit = 1'b1; alarm_hit = 1'b1;
    repeat (3) @(negedge PixelClk);
    chk("rst_lcd", {16'h0, LCD_R, LCD_G, LCD_B}, 32'd0);
    chk("rst_page", {30'h0, page}, 32'd0);
    chk("rst_blink", {31'h0, blink}, 32'd0);
    chk("rst_fs", {31'h0, frame_start}, 32'd0);
    nRST = 1'b1;

    //        pg    mode  req   ack   sa    bl    early
    // steady mode after reset: no banner
    run_frame(2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // mode change mid-frame -> banner for 3 frames
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // alarm during banner, ack two frames later
    run_frame(2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // req and ack together: request wins, alarm holds until a later ack
    run_frame(2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // mode change while in alarm is held, banner follows the ack
    run_frame(2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // blink: toggles every 2 frame_starts, clears at once when editing stops
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge PixelClk);
    if (sb.size() > 0) chk("lcd", {16'h0, LCD_R, LCD_G, LCD_B}, {16'h0, sb.pop_front()});
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
